// File: rtl/codeseq_pkg.sv
// Shared types and helpers for the codeseq bit packer.
// Latency: n/a (package).
// Backpressure: n/a (package).
package codeseq_pkg;

    localparam int CODESEQ_ADDR_W  = 16;
    localparam int CODESEQ_MAX_LEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Keeps the low 'len' bits of a codeword; any length of 32 or more keeps all bits.
    function automatic logic [CODESEQ_MAX_LEN-1:0] len_mask(input logic [5:0] len);
        logic [CODESEQ_MAX_LEN-1:0] m;
        if (len >= 6'(CODESEQ_MAX_LEN)) begin
            m = '1;
        end else begin
            m = (CODESEQ_MAX_LEN'(1) << len) - CODESEQ_MAX_LEN'(1);
        end
        return m;
    endfunction

    // Lengths above the maximum are treated as the maximum.
    function automatic logic [5:0] len_clamp(input logic [5:0] len);
        return (len > 6'(CODESEQ_MAX_LEN)) ? 6'(CODESEQ_MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/codeseq_bitacc.sv
// Bit accumulator: shifts codewords in LSB-first above the pending bits and drains bytes from the bottom.
// Latency: a byte completed at one edge is offered on wr_vld/wr_dat during the following cycle.
// Backpressure: none internally; the caller must stop pushing while bit_cnt > ACC_W-33.
module codeseq_bitacc
    import codeseq_pkg::*;
#(
    parameter int ACC_W = 64,
    localparam int CNT_W = $clog2(ACC_W + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       drain_en,
    input  logic                       pad_en,
    input  logic                       push,
    input  logic [CODESEQ_MAX_LEN-1:0] push_code,
    input  logic [5:0]                 push_len,
    input  logic                       push_stop,
    output logic                       wr_vld,
    output logic [7:0]                 wr_dat,
    output logic [CNT_W-1:0]           bit_cnt
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] code_ext;
    logic             drain;
    logic             pad;

    // Bits above cnt_q are always zero, so a partial byte is already zero-padded.
    assign drain    = drain_en && (cnt_q >= CNT_W'(8));
    assign pad      = pad_en && !drain && (cnt_q != '0);
    assign wr_vld   = drain || pad;
    assign wr_dat   = acc_q[7:0];
    assign bit_cnt  = cnt_q;
    assign code_ext = ACC_W'(push_code & len_mask(push_len));

    // Next accumulator: remove the outgoing byte first, then append the codeword and stop bit above what remains.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (drain) begin
            acc_d = acc_q >> 8;
            cnt_d = cnt_q - CNT_W'(8);
        end else if (pad) begin
            acc_d = '0;
            cnt_d = '0;
        end
        if (push) begin
            acc_d = acc_d | (code_ext << cnt_d);
            cnt_d = cnt_d + CNT_W'(push_len);
        end
        if (push_stop) begin
            acc_d = acc_d | (ACC_W'(1) << cnt_d);
            cnt_d = cnt_d + CNT_W'(1);
        end
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    // Accumulator and bit count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/codeseq_packer.sv
// Packs 1..32-bit codewords LSB-first into bytes written to the codeseq SRAM (CODESEQ_STOPBIT_EN adds a terminating '1' bit).
// Latency: a byte completed at edge N is written (mem_wen/mem_addr/mem_d registered) at edge N+1.
// Backpressure: in_ready drops while more than ACC_W-33 bits are pending or when not in RUN.
module codeseq_packer
    import codeseq_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          ACC_W     = 64          // must be >= 40 so a full codeword plus stop bit always fits
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_code,
    input  logic [5:0]  in_len,
    input  logic        in_last,
    output logic        mem_wen,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_d,
    output logic        done,
    output logic        overflow,
    output logic [16:0] byte_count
);

    localparam int CNT_W = $clog2(ACC_W + 1);

    state_e                    state_q, state_d;
    logic [CODESEQ_ADDR_W-1:0] addr_q, addr_d;
    logic                      addr_end_q, addr_end_d;   // address FFFF has been consumed
    logic                      mem_wen_q, mem_wen_d;
    logic [CODESEQ_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]               mem_d_q, mem_d_d;
    logic                      overflow_q, overflow_d;
    logic [16:0]               byte_count_q, byte_count_d;

    logic             accept;
    logic             stop_bit;
    logic             wr_vld;
    logic [7:0]       wr_dat;
    logic [CNT_W-1:0] bit_cnt;

    assign in_ready = (state_q == RUN) && (bit_cnt <= CNT_W'(ACC_W - 33));
    assign accept   = in_valid && in_ready && !start;

`ifdef CODESEQ_STOPBIT_EN
    assign stop_bit = accept && in_last;
`else
    assign stop_bit = 1'b0;
`endif

    codeseq_bitacc #(
        .ACC_W(ACC_W)
    ) u_bitacc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start),
        .drain_en  ((state_q == RUN) || (state_q == FLUSH)),
        .pad_en    (state_q == FLUSH),
        .push      (accept),
        .push_code (in_code),
        .push_len  (len_clamp(in_len)),
        .push_stop (stop_bit),
        .wr_vld    (wr_vld),
        .wr_dat    (wr_dat),
        .bit_cnt   (bit_cnt)
    );

    // Stream FSM: start always wins, last codeword moves to FLUSH, empty accumulator completes the stream.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            RUN:     if (accept && in_last) state_d = FLUSH;
            FLUSH:   if (bit_cnt == '0) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d = RUN;
        end
    end

    // SRAM port, address and overflow: writes past the last address are dropped and flagged.
    always_comb begin
        addr_d       = addr_q;
        addr_end_d   = addr_end_q;
        mem_wen_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_d_d      = mem_d_q;
        overflow_d   = overflow_q;
        byte_count_d = byte_count_q;
        if (start) begin
            addr_d       = BASE_ADDR;
            addr_end_d   = 1'b0;
            mem_addr_d   = BASE_ADDR;
            mem_d_d      = '0;
            overflow_d   = 1'b0;
            byte_count_d = '0;
        end else if (wr_vld) begin
            if (addr_end_q) begin
                overflow_d = 1'b1;
            end else begin
                mem_wen_d    = 1'b1;
                mem_addr_d   = addr_q;
                mem_d_d      = {24'b0, wr_dat};
                byte_count_d = byte_count_q + 17'd1;
                if (addr_q == '1) begin
                    addr_end_d = 1'b1;
                end else begin
                    addr_d = addr_q + CODESEQ_ADDR_W'(1);
                end
            end
        end
    end

    // Control and SRAM port registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= BASE_ADDR;
            addr_end_q   <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= BASE_ADDR;
            mem_d_q      <= '0;
            overflow_q   <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            addr_end_q   <= addr_end_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_d_q      <= mem_d_d;
            overflow_q   <= overflow_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign mem_wen    = mem_wen_q;
    assign mem_addr   = mem_addr_q;
    assign mem_d      = mem_d_q;
    assign done       = (state_q == DONE);
    assign overflow   = overflow_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_codeseq_packer.sv
// Directed bench for codeseq_packer with a bit-level reference model feeding a write scoreboard.
// Latency: checks first write exactly one cycle after the completing accept.
// Backpressure: holds in_valid high through stalls and checks no bits are lost.
module tb_codeseq_packer;

`ifdef CODESEQ_STOPBIT_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, in_last;
    logic [31:0] in_code;
    logic [5:0]  in_len;

    logic        in_ready_a, mem_wen_a, done_a, overflow_a;
    logic [15:0] mem_addr_a;
    logic [31:0] mem_d_a;
    logic [16:0] byte_count_a;
    logic        in_ready_b, mem_wen_b, done_b, overflow_b;
    logic [15:0] mem_addr_b;
    logic [31:0] mem_d_b;
    logic [16:0] byte_count_b;

    always #5 clk = ~clk;

    codeseq_packer #(.BASE_ADDR(16'h0000), .ACC_W(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_code(in_code), .in_len(in_len), .in_last(in_last), .mem_wen(mem_wen_a),
        .mem_addr(mem_addr_a), .mem_d(mem_d_a), .done(done_a), .overflow(overflow_a),
        .byte_count(byte_count_a)
    );

    codeseq_packer #(.BASE_ADDR(16'hFFFE), .ACC_W(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_code(in_code), .in_len(in_len), .in_last(in_last), .mem_wen(mem_wen_b),
        .mem_addr(mem_addr_b), .mem_d(mem_d_b), .done(done_b), .overflow(overflow_b),
        .byte_count(byte_count_b)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  dat;
    } wr_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_stall = 0;
    wr_t         exp_q[$];
    wr_t         blog[$];
    bit          mbits[$];
    logic [15:0] exp_addr = 16'h0;
    int          exp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_drain();
        while (mbits.size() >= 8) begin
            wr_t w;
            for (int i = 0; i < 8; i++) w.dat[i] = mbits.pop_front();
            w.addr = exp_addr;
            exp_q.push_back(w);
            exp_addr = exp_addr + 16'd1;
            exp_cnt++;
        end
    endtask

    task automatic model_push(input logic [31:0] code, input int len);
        int l;
        l = (len > 32) ? 32 : len;
        for (int i = 0; i < l; i++) mbits.push_back(code[i]);
        model_drain();
    endtask

    task automatic model_flush();
        if (STOP) mbits.push_back(1'b1);
        while ((mbits.size() % 8) != 0) mbits.push_back(1'b0);
        model_drain();
    endtask

    // Scoreboard: every write of DUT A must match the next modelled byte; DUT B writes are logged.
    always @(negedge clk) begin
        if (mem_wen_a) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", 32'(mem_addr_a), 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("sb_addr", 32'(mem_addr_a), 32'(w.addr));
                check("sb_data", mem_d_a, {24'h0, w.dat});
            end
        end
        if (mem_wen_b) blog.push_back('{mem_addr_b, mem_d_b[7:0]});
    end

    task automatic send(input logic [31:0] code, input int len, input bit last);
        int waitc;
        waitc = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = code;
        in_len   = len[5:0];
        in_last  = last;
        while (!in_ready_a && waitc < 200) begin
            n_stall++;
            @(negedge clk);
            waitc++;
        end
        if (!in_ready_a) check("send_ready_timeout", 32'(in_ready_a), 32'd1);
        @(posedge clk);
        model_push(code, len);
        if (last) model_flush();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mbits.delete();
        exp_addr = 16'h0;
        exp_cnt  = 0;
    endtask

    task automatic wait_done(input string tag);
        int waitc;
        waitc = 0;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        while (!done_a && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, "_done"}, 32'(done_a), 32'd1);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_wen"}, 32'(mem_wen_a), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr_a), 32'h0);
        check({tag, "_d"}, mem_d_a, 32'h0);
        check({tag, "_done"}, 32'(done_a), 32'd0);
        check({tag, "_ovf"}, 32'(overflow_a), 32'd0);
        check({tag, "_bc"}, 32'(byte_count_a), 32'd0);
        check({tag, "_rdy"}, 32'(in_ready_a), 32'd0);
        check({tag, "_addr_b"}, 32'(mem_addr_b), 32'hFFFE);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] t1 [9];
        t1 = '{8'h8B, 8'h57, 8'hF5, 8'h3F, 8'h19, 8'hD0, 8'h62, 8'hCB, 8'hBE};
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_code = '0; in_len = '0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst0");
        rst_n = 1'b1;
        // IDLE ignores in_valid
        in_valid = 1'b1; in_code = 32'hFF; in_len = 6'd8;
        repeat (3) @(negedge clk);
        check("idle_rdy", 32'(in_ready_a), 32'd0);
        in_valid = 1'b0;

        // 1: aligned bytes
        pulse_start();
        check("t1_rdy_run", 32'(in_ready_a), 32'd1);
        for (int i = 0; i < 9; i++) send(32'(t1[i]), 8, i == 8);
        wait_done("t1");
        check("t1_bc", 32'(byte_count_a), 32'(9 + int'(STOP)));

        // 2: split byte, exact latency
        pulse_start();
        send(32'b011, 3, 1'b0);
        send(32'b10001, 5, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_lat_early", 32'(mem_wen_a), 32'd0);
        @(negedge clk);
        check("t2_wen", 32'(mem_wen_a), 32'd1);
        check("t2_addr", 32'(mem_addr_a), 32'h0);
        check("t2_d", mem_d_a, 32'h0000_008B);
        @(negedge clk);
        check("t2_single", 32'(mem_wen_a), 32'd0);

        // 3: backpressure with 32-bit codes, plus clamped and zero-length codes
        pulse_start();
        n_stall = 0;
        for (int i = 0; i < 8; i++) send($urandom(), 32, 1'b0);
        send($urandom(), 40, 1'b0);
        send($urandom(), 17, 1'b0);
        send(32'hFFFF_FFFF, 0, 1'b1);
        wait_done("t3");
        check("t3_stalled", 32'(n_stall > 0), 32'd1);
        check("t3_bc", 32'(byte_count_a), 32'(exp_cnt));

        // 4: partial flush, then quiet
        pulse_start();
        send(32'hA, 4, 1'b1);
        wait_done("t4");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_quiet", 32'(mem_wen_a), 32'd0);
        end
        check("t4_bc", 32'(byte_count_a), 32'd1);

        // 5: address wrap on DUT B
        pulse_start();
        blog.delete();
        send(32'hA1, 8, 1'b0);
        send(32'hA2, 8, 1'b0);
        send(32'hA3, 8, 1'b1);
        wait_done("t5");
        check("t5_nwr", 32'(blog.size()), 32'd2);
        if (blog.size() == 2) begin
            check("t5_addr0", 32'(blog[0].addr), 32'hFFFE);
            check("t5_d0", 32'(blog[0].dat), 32'hA1);
            check("t5_addr1", 32'(blog[1].addr), 32'hFFFF);
            check("t5_d1", 32'(blog[1].dat), 32'hA2);
        end
        check("t5_ovf", 32'(overflow_b), 32'd1);
        check("t5_bc", 32'(byte_count_b), 32'd2);
        check("t5_ovf_a", 32'(overflow_a), 32'd0);

        // 6: reset mid-stream, then a fresh stream
        pulse_start();
        send(32'h11, 8, 1'b0);
        send(32'h1F, 5, 1'b0);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset("t6_rst");
        check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        mbits.delete();
        rst_n = 1'b1;
        pulse_start();
        send(32'h5, 4, 1'b1);
        wait_done("t6");
        check("t6_bc", 32'(byte_count_a), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
